vector_mem_unit: RTL and testbench

- Vector load/store sequencer between the execute stage and the 8-bit image data memory. The memory spaces lanes 8 bytes apart, writes 16 lanes per cycle, and returns only 8 read lanes.
- Accepts one 16-element vector request per handshake.
- Loads take two read beats and merge them into one 16x16 response. Stores take one write beat and clamp each element to 8 bits.
- Range-checks addresses against the image size.

---
 rtl/vmem_pkg.sv | 22 ++
 rtl/pix_saturate.sv | 23 ++
 rtl/vector_mem_unit.sv | 134 +++++++++++++
 tb/tb_vector_mem_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector load/store sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vmem_pkg;

  localparam int LANES       = 16;
  localparam int READ_LANES  = 8;
  localparam int LANE_STRIDE = 8;
  localparam int MEM_DEPTH   = 96 * 96;

  // 16 lanes of 16 bits; lane i lives in [i].
  typedef logic [15:0][15:0] vec16_t;

  typedef enum logic [2:0] {
    IDLE,
    LD0,
    LD1,
    ST,
    RESP
  } vmem_state_t;

endpackage

// File: rtl/pix_saturate.sv
// Combinational 16-bit element to 8-bit pixel conversion (clamp or truncate).
// Latency: 0 cycles, purely combinational.
// Backpressure: none.
// Ports: din - signed-ish 16-bit store element; dout - 8-bit pixel.
module pix_saturate #(
  parameter int SATURATE = 1
) (
  input  logic [15:0] din,
  output logic [7:0]  dout
);

  always_comb begin
    dout = din[7:0];
    if (SATURATE != 0) begin
      // bit15 marks a negative element; anything above 255 pins to white.
      if (din[15])
        dout = 8'h00;
      else if (|din[14:8])
        dout = 8'hFF;
    end
  end

endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer between execute and the 8-bit image memory.
// Latency: accept->resp_valid 3 cycles (load), 2 (store), 1 (range error).
// Backpressure: req_ready only in IDLE; response held until resp_ready.
// Ports: CLK/RST_N; req_* request channel (valid/ready); resp_* response
// channel (valid/ready, data + err); mem_* combinational memory interface.
module vector_mem_unit
  import vmem_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 96,
  parameter int IMAGE_HEIGHT = 96,
  parameter int SATURATE     = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_base,
  input  vec16_t      req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output vec16_t      resp_data,
  output logic        resp_err,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output vec16_t      mem_wd,
  input  vec16_t      mem_rd
);

  localparam logic [16:0] LAST_OK  = 17'(IMAGE_WIDTH * IMAGE_HEIGHT - 1);
  localparam logic [16:0] SPAN     = 17'((LANES - 1) * LANE_STRIDE);
  localparam logic [15:0] HI_OFFS  = 16'(READ_LANES * LANE_STRIDE);

  vmem_state_t state_q, state_d;
  logic [15:0] base_q;
  vec16_t      wdata_q;
  vec16_t      wd_clamped;
  logic [16:0] last_addr;
  logic        range_err;
  logic        accept;

  // Only the low READ_LANES lanes and their low byte carry read data.
  logic unused_rd;
  assign unused_rd = ^mem_rd;

  // 17-bit sum so a base near 0xFFFF cannot wrap back into range.
  assign last_addr = {1'b0, req_base} + SPAN;
  assign range_err = last_addr > LAST_OK;
  assign accept    = req_valid && req_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_sat
    pix_saturate #(.SATURATE(SATURATE)) u_sat (
      .din  (wdata_q[i]),
      .dout (wd_clamped[i][7:0])
    );
    assign wd_clamped[i][15:8] = 8'h00;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Memory strobes are decoded from state so a reset drops them at once.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = 16'h0000;
    mem_we     = 1'b0;
    mem_wd     = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (range_err)
            state_d = RESP;
          else if (req_we)
            state_d = ST;
          else
            state_d = LD0;
        end
      end
      LD0: begin
        mem_addr = base_q;
        state_d  = LD1;
      end
      LD1: begin
        // Range check at accept guarantees this cannot wrap.
        mem_addr = base_q + HI_OFFS;
        state_d  = RESP;
      end
      ST: begin
        mem_addr = base_q;
        mem_we   = 1'b1;
        mem_wd   = wd_clamped;
        state_d  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      base_q    <= 16'h0000;
      wdata_q   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      if (accept) begin
        base_q    <= req_base;
        wdata_q   <= req_wdata;
        resp_data <= '0;
        resp_err  <= range_err;
      end
      if (state_q == LD0) begin
        for (int k = 0; k < READ_LANES; k++)
          resp_data[k] <= {8'h00, mem_rd[k][7:0]};
      end
      if (state_q == LD1) begin
        for (int k = 0; k < READ_LANES; k++)
          resp_data[READ_LANES + k] <= {8'h00, mem_rd[k][7:0]};
      end
    end
  end

endmodule

// File: tb/tb_vector_mem_unit.sv
module tb_vector_mem_unit;
  import vmem_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_base;
  vec16_t      req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  vec16_t      resp_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  vec16_t      mem_wd, mem_rd;

  logic [7:0] mem [0:9215];
  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int cyc = 0;

  vector_mem_unit dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_base(req_base), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: combinational read of 8 lanes, commit on falling edge.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      int idx;
      idx = int'(mem_addr) + 8 * k;
      if (k < 8 && idx < 9216)
        mem_rd[k] = {8'h00, mem[idx]};
      else
        mem_rd[k] = 16'hBEEF;
    end
  end

  always @(negedge CLK) begin
    if (mem_we) begin
      we_cnt = we_cnt + 1;
      for (int i = 0; i < 16; i++)
        if (int'(mem_addr) + 8 * i < 9216)
          mem[int'(mem_addr) + 8 * i] = mem_wd[i][7:0];
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [15:0] base, input vec16_t wd);
    req_valid = 1'b1;
    req_we    = we;
    req_base  = base;
    req_wdata = wd;
  endtask

  initial begin
    vec16_t e, wd;
    int w0, t0, t1;

    for (int a = 0; a < 9216; a++) mem[a] = 8'(a);
    req_valid = 1'b0; req_we = 1'b0; req_base = '0; req_wdata = '0;
    resp_ready = 1'b1;

    // Reset values
    #2;
    check("rst_req_ready", 256'(req_ready), 256'(1));
    check("rst_resp_valid", 256'(resp_valid), 256'(0));
    check("rst_resp_data", 256'(resp_data), 256'(0));
    check("rst_resp_err", 256'(resp_err), 256'(0));
    check("rst_mem_addr", 256'(mem_addr), 256'(0));
    check("rst_mem_we", 256'(mem_we), 256'(0));
    check("rst_mem_wd", 256'(mem_wd), 256'(0));
    #10 RST_N = 1'b1;
    tick();

    // Load base 0x0010
    for (int k = 0; k < 16; k++) e[k] = 16'((16 + 8 * k) & 255);
    drive(1'b0, 16'h0010, '0);
    tick();
    req_valid = 1'b0;
    check("ld_addr0", 256'(mem_addr), 256'(16'h0010));
    check("ld_busy", 256'(req_ready), 256'(0));
    check("ld_nvalid0", 256'(resp_valid), 256'(0));
    tick();
    check("ld_addr1", 256'(mem_addr), 256'(16'h0050));
    check("ld_nvalid1", 256'(resp_valid), 256'(0));
    tick();
    check("ld_valid", 256'(resp_valid), 256'(1));
    check("ld_data", 256'(resp_data), 256'(e));
    check("ld_err", 256'(resp_err), 256'(0));
    tick();
    check("ld_done_valid", 256'(resp_valid), 256'(0));
    check("ld_done_ready", 256'(req_ready), 256'(1));

    // Store base 0x0100, clamping
    for (int i = 0; i < 16; i++) begin
      wd[i] = 16'(i * 20);
      e[i]  = (i * 20 < 256) ? 16'(i * 20) : 16'h00FF;
    end
    wd[0] = 16'h8000; e[0] = 16'h0000;
    wd[1] = 16'hFF7F; e[1] = 16'h0000;
    w0 = we_cnt;
    drive(1'b1, 16'h0100, wd);
    tick();
    req_valid = 1'b0;
    check("st_we", 256'(mem_we), 256'(1));
    check("st_addr", 256'(mem_addr), 256'(16'h0100));
    check("st_wd", 256'(mem_wd), 256'(e));
    tick();
    check("st_we_off", 256'(mem_we), 256'(0));
    check("st_valid", 256'(resp_valid), 256'(1));
    check("st_resp_data", 256'(resp_data), 256'(0));
    check("st_err", 256'(resp_err), 256'(0));
    check("st_we_cycles", 256'(we_cnt - w0), 256'(1));
    check("st_mem_l1", 256'(mem[16'h0108]), 256'(8'h00));
    check("st_mem_l2", 256'(mem[16'h0110]), 256'(8'h28));
    check("st_mem_l12", 256'(mem[16'h0160]), 256'(8'hF0));
    check("st_mem_l13", 256'(mem[16'h0168]), 256'(8'hFF));
    tick();

    // Load near top of image, in range
    for (int k = 0; k < 16; k++) e[k] = 16'((16'h81 + 8 * k) & 255);
    drive(1'b0, 16'h2381, '0);
    tick();
    req_valid = 1'b0;
    check("hi_nvalid", 256'(resp_valid), 256'(0));
    check("hi_addr0", 256'(mem_addr), 256'(16'h2381));
    tick();
    tick();
    check("hi_valid", 256'(resp_valid), 256'(1));
    check("hi_err", 256'(resp_err), 256'(0));
    check("hi_data", 256'(resp_data), 256'(e));
    tick();

    // Out of range
    w0 = we_cnt;
    drive(1'b0, 16'h2390, '0);
    tick();
    req_valid = 1'b0;
    check("oor_valid", 256'(resp_valid), 256'(1));
    check("oor_err", 256'(resp_err), 256'(1));
    check("oor_data", 256'(resp_data), 256'(0));
    check("oor_addr", 256'(mem_addr), 256'(0));
    tick();
    check("oor_done", 256'(resp_valid), 256'(0));
    check("oor_no_we", 256'(we_cnt - w0), 256'(0));
    check("oor_ready", 256'(req_ready), 256'(1));

    // Response held under backpressure
    resp_ready = 1'b0;
    for (int k = 0; k < 16; k++) e[k] = 16'(8 * k);
    drive(1'b0, 16'h0000, '0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 16; i++) wd[i] = 16'h0033;
    drive(1'b1, 16'h0300, wd);
    for (int n = 0; n < 5; n++) begin
      check("hold_valid", 256'(resp_valid), 256'(1));
      check("hold_ready", 256'(req_ready), 256'(0));
      check("hold_data", 256'(resp_data), 256'(e));
      tick();
    end
    resp_ready = 1'b1;
    tick();
    check("hs_idle_ready", 256'(req_ready), 256'(1));
    check("hs_idle_valid", 256'(resp_valid), 256'(0));
    check("hs_no_accept", 256'(mem_we), 256'(0));
    tick();
    req_valid = 1'b0;
    check("hs_accept_we", 256'(mem_we), 256'(1));
    check("hs_accept_addr", 256'(mem_addr), 256'(16'h0300));
    tick();
    tick();

    // Reset during ST
    for (int i = 0; i < 16; i++) wd[i] = 16'h0055;
    w0 = we_cnt;
    drive(1'b1, 16'h0200, wd);
    tick();
    req_valid = 1'b0;
    check("ar_we_before", 256'(mem_we), 256'(1));
    #1 RST_N = 1'b0;
    #1;
    check("ar_we", 256'(mem_we), 256'(0));
    check("ar_req_ready", 256'(req_ready), 256'(1));
    check("ar_resp_valid", 256'(resp_valid), 256'(0));
    check("ar_mem_addr", 256'(mem_addr), 256'(0));
    check("ar_mem_wd", 256'(mem_wd), 256'(0));
    check("ar_resp_err", 256'(resp_err), 256'(0));
    #4 RST_N = 1'b1;
    tick();
    check("ar_no_write_cnt", 256'(we_cnt - w0), 256'(0));
    check("ar_mem_l0", 256'(mem[16'h0200]), 256'(8'h00));
    check("ar_mem_l1", 256'(mem[16'h0208]), 256'(8'h08));
    check("ar_ready_after", 256'(req_ready), 256'(1));
    check("ar_valid_after", 256'(resp_valid), 256'(0));

    // Back-to-back load then store
    resp_ready = 1'b1;
    drive(1'b0, 16'h0040, '0);
    t0 = cyc;
    tick();
    for (int i = 0; i < 16; i++) begin
      wd[i] = 16'(i + 1);
      e[i]  = 16'(i + 1);
    end
    drive(1'b1, 16'h0400, wd);
    for (int n = 0; n < 10; n++)
      if (!req_ready) tick();
    t1 = cyc;
    tick();
    req_valid = 1'b0;
    check("b2b_spacing", 256'(t1 - t0), 256'(4));
    check("b2b_we", 256'(mem_we), 256'(1));
    check("b2b_addr", 256'(mem_addr), 256'(16'h0400));
    check("b2b_wd", 256'(mem_wd), 256'(e));
    tick();
    check("b2b_valid", 256'(resp_valid), 256'(1));
    tick();
    check("b2b_mem_l0", 256'(mem[16'h0400]), 256'(8'h01));
    check("b2b_mem_l15", 256'(mem[16'h0478]), 256'(8'h10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
